iter_multdiv: RTL and testbench
===============================

# iter_multdiv

Parametrised iterative multiply/divide unit for the pipelined processor's X stage, generalising the fixed 32-bit multdiv. Adds a signed/unsigned mode, a cancel input for pipeline flushes, early completion on divide-by-zero, and overflow detection for both operations. The X stage issues a one-cycle start pulse and stalls PC/FD/DX/XM/MW until `ready` pulses.

## Interface

Parameters:
- `WIDTH`, 32: operand and result width; any value ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.

Ports:
- `clock` in 1: master clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `operand_a` in WIDTH: multiplicand or dividend; sampled only on an accepted start.
- `operand_b` in WIDTH: multiplier or divisor; sampled only on an accepted start.
- `ctrl_mult` in 1: start-multiply pulse.
- `ctrl_div` in 1: start-divide pulse.
- `sign_mode` in 1: 1 selects signed (two's complement), 0 selects unsigned; sampled with start.
- `cancel` in 1: abort the operation in flight.
- `result` out WIDTH: product (low WIDTH bits) or quotient; registered.
- `exception` out 1: overflow or divide-by-zero for the last completed operation; registered.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high while in RUN.

## Operation

- States: IDLE, RUN, DONE. Reset → IDLE.
- Accepted start: state is IDLE or DONE, exactly one of `ctrl_mult`/`ctrl_div` is high, and `cancel` is low.
  - On acceptance, latch the op type, `sign_mode`, operand magnitudes (absolute value if signed) and the result sign.
  - Clear the counter; next state RUN.
- Both start pulses high together: ignored, no state change. A start received in RUN is ignored.
- Multiply: radix-2 shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle. Only the quotient is returned; the remainder is discarded.
- Final fix-up: negate the magnitude result if signed and the result sign is negative.
- Division truncates toward zero.
- Exception rules:
  - Unsigned multiply: the upper WIDTH bits of the product are nonzero.
  - Signed multiply: the full product does not fit in WIDTH-bit two's complement.
  - Divide by zero: `exception` = 1 and `result` = 0.
  - Signed divide of most-negative by −1: `exception` = 1 and `result` = most-negative.
  - In every overflow case other than divide-by-zero, `result` is the low WIDTH bits of the true value.
- Divide-by-zero completes early: RUN lasts exactly one cycle, skipping the remaining iterations.
- `cancel` in RUN: next state IDLE. No `ready`; `result` and `exception` keep their previous values. `cancel` in IDLE or DONE only blocks a start in that cycle.
- DONE lasts one cycle, then IDLE unless a new start is accepted.
- `result` and `exception` are written on entry to DONE and hold until the next entry to DONE or reset.

## Timing

- Start sampled at edge E0. Iterations run at edges E1…E(WIDTH); the DONE transition happens on E(WIDTH).
- `ready` is high for the single cycle after E(WIDTH), giving a latency of WIDTH cycles (32 at the default).
- Divide-by-zero: DONE on E1, so `ready` is high after E1.
- `busy` = (state == RUN). `ready` = (state == DONE). Both are registered state decodes, so neither has a combinational path from any input.
- Back-to-back: a start accepted in the DONE cycle enters RUN on the next edge, so `ready` and a new start can coincide.
- Reset (low at an edge) overrides everything, including a simultaneous start or cancel. After that edge:
  - state = IDLE
  - `result` = 0, `exception` = 0
  - `ready` = 0, `busy` = 0
  - counter = 0
- Reset mid-RUN discards the operation with no `ready`.
- `cancel` and the final iteration edge coinciding: `cancel` wins, so there is no DONE and no `ready`.
- Operand inputs may change freely after E0 without affecting the operation.

## Test plan

- WIDTH=32, signed: mult 7 × −6 → `ready` 32 cycles after the start edge, `result` = 0xFFFFFFD6 (−42), `exception` = 0. `busy` is high for exactly 32 cycles.
- WIDTH=32, signed: div −7 / 2 → `result` = 0xFFFFFFFD (−3). Then div 0x80000000 / −1 → `result` = 0x80000000, `exception` = 1.
- WIDTH=32: div 5 / 0 → `ready` one cycle after the start edge, `result` = 0, `exception` = 1.
- WIDTH=8, unsigned: mult 0x10 × 0x10 → `result` = 0x00, `exception` = 1, `ready` after 8 cycles. Then mult 0x0F × 0x11 → `result` = 0xFF, `exception` = 0.
- WIDTH=32: start mult, assert `cancel` at cycle 10 → `busy` drops, `ready` is never seen, `result` and `exception` are unchanged. A start issued in the same cycle as a `ready` is accepted and completes 32 cycles later.
- WIDTH=32: pull `reset` low mid-RUN → all outputs 0 the next cycle. Both start pulses high together → no `busy`. A start asserted while `busy` → ignored, and the in-flight `result` is unaffected.

Source files
------------

// File: rtl/iter_multdiv.sv
// iter_multdiv: iterative multiply/divide unit for the X stage.
//   Multiply is radix-2 shift-add, one multiplier bit per cycle. Divide is restoring
//   division, one quotient bit per cycle, returning the quotient only. Operands are
//   latched as magnitudes, and the sign is re-applied on the final iteration.
// Ports:
//   clock, reset        - clock; synchronous active-low reset
//   operand_a/_b        - multiplicand/dividend, multiplier/divisor (sampled on start)
//   ctrl_mult, ctrl_div - one-cycle start pulses (exactly one must be high)
//   sign_mode           - 1: two's complement, 0: unsigned (sampled on start)
//   cancel              - abort the operation in flight
//   result, exception   - last completed result and its overflow/div-by-zero flag
//   ready               - one-cycle completion pulse (state DONE)
//   busy                - high while iterating (state RUN)
module iter_multdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             sign_mode,
  input  logic             cancel,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             ready_q, busy_q;

  // Start acceptance and operand magnitudes
  logic             start_ok;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_ok = (state_q != S_RUN) && (ctrl_mult ^ ctrl_div) && !cancel;
  assign a_neg    = sign_mode & operand_a[WIDTH-1];
  assign b_neg    = sign_mode & operand_b[WIDTH-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;

  // One iteration of either algorithm
  logic [WIDTH:0]   mul_sum, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    acc_step;

  assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opnd_q};
  // Remainder stays below the divisor, so the top trial bit is always dropped safely
  assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opnd_q}) : div_trial[WIDTH-1:0];
  assign acc_step  = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                              : {mul_sum, acc_q[WIDTH-1:1]};

  // Sign fix-up and overflow detection on the final iteration
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s;
  logic             mul_ovf, div_ovf;

  assign prod_s  = neg_q ? -acc_step : acc_step;
  assign quo_s   = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  // Signed product fits only if bits [W2-1:WIDTH-1] are a pure sign extension
  assign mul_ovf = sgn_q ? (prod_s[W2-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}})
                         : (|acc_step[W2-1:WIDTH]);
  // Only most-negative / -1 yields a positive quotient magnitude of 2^(WIDTH-1)
  assign div_ovf = sgn_q & ~neg_q & acc_step[WIDTH-1];

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (is_div_q && (opnd_q == '0)) begin
          state_d  = S_DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            result_d = is_div_q ? quo_s : prod_s[WIDTH-1:0];
            exc_d    = is_div_q ? div_ovf : mul_ovf;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start_ok) begin
          state_d  = S_RUN;
          is_div_d = ctrl_div;
          sgn_d    = sign_mode;
          neg_d    = a_neg ^ b_neg;
          opnd_d   = ctrl_div ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (ctrl_div ? a_mag : b_mag)};
          cnt_d    = '0;
        end
      end
    endcase
  end

  // Registers; busy/ready are flopped decodes of the next state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ready_q  <= (state_d == S_DONE);
      busy_q   <= (state_d == S_RUN);
    end
  end

  assign result    = result_q;
  assign exception = exc_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// tb_iter_multdiv: directed bench for iter_multdiv at WIDTH=32 and WIDTH=8.
module tb_iter_multdiv;

  logic        clk, rst_n;
  logic [31:0] a32, b32, r32;
  logic        m32, d32, s32, c32, e32, rdy32, bsy32;
  logic [7:0]  a8, b8, r8;
  logic        m8, d8, s8, c8, e8, rdy8, bsy8;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  iter_multdiv #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset(rst_n), .operand_a(a32), .operand_b(b32),
    .ctrl_mult(m32), .ctrl_div(d32), .sign_mode(s32), .cancel(c32),
    .result(r32), .exception(e32), .ready(rdy32), .busy(bsy32)
  );

  iter_multdiv #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst_n), .operand_a(a8), .operand_b(b8),
    .ctrl_mult(m8), .ctrl_div(d8), .sign_mode(s8), .cancel(c8),
    .result(r8), .exception(e8), .ready(rdy8), .busy(bsy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start32(input logic is_div, input logic sm, input logic [31:0] a, input logic [31:0] b);
    a32 = a; b32 = b; s32 = sm; m32 = ~is_div; d32 = is_div;
    tick();
    m32 = 1'b0; d32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = ~sm;
  endtask

  task automatic wait32(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bsy32 ? 1 : 0;
    while (rdy32 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
      if (bsy32) bcnt++;
    end
  endtask

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b, output int lat);
    a8 = a; b8 = b; s8 = sm; m8 = 1'b1;
    tick();
    m8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (rdy8 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, seen;
    rst_n = 1'b0;
    {a32, b32, m32, d32, s32, c32} = '0;
    {a8, b8, m8, d8, s8, c8} = '0;
    tick(); tick();
    check("rst_result32", 64'(r32), 64'h0);
    check("rst_exc32",    64'(e32), 64'h0);
    check("rst_ready32",  64'(rdy32), 64'h0);
    check("rst_busy32",   64'(bsy32), 64'h0);
    check("rst_result8",  64'(r8), 64'h0);
    check("rst_busy8",    64'(bsy8), 64'h0);
    rst_n = 1'b1;
    tick();

    // signed 7 * -6 = -42
    start32(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFA);
    wait32(lat, bcnt);
    check("smul_lat",    64'(lat), 64'd32);
    check("smul_busy",   64'(bcnt), 64'd32);
    check("smul_result", 64'(r32), 64'hFFFF_FFD6);
    check("smul_exc",    64'(e32), 64'h0);
    tick();

    // signed -7 / 2 = -3 (truncate toward zero)
    start32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait32(lat, bcnt);
    check("sdiv_lat",    64'(lat), 64'd32);
    check("sdiv_result", 64'(r32), 64'hFFFF_FFFD);
    check("sdiv_exc",    64'(e32), 64'h0);
    tick();

    // most-negative / -1 overflows
    start32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait32(lat, bcnt);
    check("ovdiv_result", 64'(r32), 64'h8000_0000);
    check("ovdiv_exc",    64'(e32), 64'h1);
    tick();

    // divide by zero completes after one cycle
    start32(1'b1, 1'b0, 32'd5, 32'd0);
    wait32(lat, bcnt);
    check("dz_lat",    64'(lat), 64'd1);
    check("dz_result", 64'(r32), 64'h0);
    check("dz_exc",    64'(e32), 64'h1);
    tick();

    // unsigned 100 / 7 = 14
    start32(1'b1, 1'b0, 32'd100, 32'd7);
    wait32(lat, bcnt);
    check("udiv_result", 64'(r32), 64'd14);
    check("udiv_exc",    64'(e32), 64'h0);
    tick();

    // unsigned 0xFFFFFFFF * 2 overflows, low bits returned
    start32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    wait32(lat, bcnt);
    check("umul_ov_result", 64'(r32), 64'hFFFF_FFFE);
    check("umul_ov_exc",    64'(e32), 64'h1);
    tick();

    // cancel at cycle 10: no ready, outputs hold
    start32(1'b0, 1'b1, 32'd3, 32'd3);
    repeat (9) tick();
    c32 = 1'b1;
    tick();
    c32 = 1'b0;
    check("cancel_busy", 64'(bsy32), 64'h0);
    seen = 0;
    repeat (40) begin
      tick();
      if (rdy32) seen++;
    end
    check("cancel_noready", 64'(seen), 64'd0);
    check("cancel_result",  64'(r32), 64'hFFFF_FFFE);
    check("cancel_exc",     64'(e32), 64'h1);

    // cancel in IDLE blocks a start
    m32 = 1'b1; c32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    tick();
    m32 = 1'b0; c32 = 1'b0;
    check("idle_cancel_busy", 64'(bsy32), 64'h0);
    tick();

    // back-to-back: new start in the ready cycle
    start32(1'b0, 1'b0, 32'd2, 32'd3);
    wait32(lat, bcnt);
    check("b2b_ready",   64'(rdy32), 64'h1);
    check("b2b_result1", 64'(r32), 64'd6);
    start32(1'b0, 1'b0, 32'd4, 32'd5);
    wait32(lat, bcnt);
    check("b2b_lat",     64'(lat), 64'd32);
    check("b2b_result2", 64'(r32), 64'd20);
    tick();

    // start while busy is ignored
    start32(1'b0, 1'b0, 32'd100, 32'd3);
    repeat (5) tick();
    d32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    tick();
    d32 = 1'b0;
    wait32(lat, bcnt);
    check("busy_start_lat",    64'(lat), 64'd26);
    check("busy_start_result", 64'(r32), 64'd300);
    check("busy_start_exc",    64'(e32), 64'h0);
    tick();

    // both start pulses together are ignored
    m32 = 1'b1; d32 = 1'b1; a32 = 32'd6; b32 = 32'd2;
    tick();
    m32 = 1'b0; d32 = 1'b0;
    check("both_busy", 64'(bsy32), 64'h0);
    tick();
    check("both_busy2", 64'(bsy32), 64'h0);
    check("both_ready", 64'(rdy32), 64'h0);

    // WIDTH=8 multiplies
    run8(1'b0, 8'h10, 8'h10, lat);
    check("m8_ov_lat",    64'(lat), 64'd8);
    check("m8_ov_result", 64'(r8), 64'h00);
    check("m8_ov_exc",    64'(e8), 64'h1);
    run8(1'b0, 8'h0F, 8'h11, lat);
    check("m8_ff_result", 64'(r8), 64'hFF);
    check("m8_ff_exc",    64'(e8), 64'h0);
    run8(1'b1, 8'h80, 8'hFF, lat);
    check("m8_sov_result", 64'(r8), 64'h80);
    check("m8_sov_exc",    64'(e8), 64'h1);
    run8(1'b1, 8'hF8, 8'h10, lat);
    check("m8_sfit_result", 64'(r8), 64'h80);
    check("m8_sfit_exc",    64'(e8), 64'h0);
    tick();

    // reset mid-RUN clears everything and no ready follows
    start32(1'b0, 1'b0, 32'd5, 32'd5);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_result", 64'(r32), 64'h0);
    check("mrst_exc",    64'(e32), 64'h0);
    check("mrst_busy",   64'(bsy32), 64'h0);
    check("mrst_ready",  64'(rdy32), 64'h0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (rdy32) seen++;
    end
    check("mrst_noready", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
